baud_tick_gen_frac: RTL and testbench

Parametrised fractional baud-tick generator for the UART datapath. It produces a one-cycle oversample tick (`o_tick`) at a runtime-programmable average period of `div_int + div_frac/2^NB_FRAC` clock cycles. It also produces a bit-rate tick (`o_bit_tick`) every `N_OVERSAMPLE` oversample ticks. The divisor loads without glitches at a period boundary, and the phase can be realigned to a detected start bit. Both UART RX and UART TX consume these ticks.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/baud_os_phase_counter.sv | 60 ++++++
 rtl/baud_tick_gen_frac.sv | 156 +++++++++++++++
 tb/tb_baud_tick_gen_frac.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants. The baud divisor is derived in fixed point with
// NB_FRAC fraction bits:
//   DIV_INT.DIV_FRAC = CLK_FREQ_HZ / (BAUD * OVERSAMPLE).
// For 50 MHz, 19200 baud and x16 oversampling this is 162 + 12/16.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int BAUD        = 19200;
  localparam int OVERSAMPLE  = 16;
  localparam int NB_FRAC     = 4;

  // Truncated fixed-point divisor. The numerator (8e8) still fits in a
  // signed 32-bit int.
  localparam int DIV_FIXED   = (CLK_FREQ_HZ * (2 ** NB_FRAC)) / (BAUD * OVERSAMPLE);
  localparam int DIV_INT     = DIV_FIXED / (2 ** NB_FRAC);
  localparam int DIV_FRAC    = DIV_FIXED % (2 ** NB_FRAC);

  // The smallest integer divisor the tick generator honours. A divisor of
  // 0 or 1 would leave no idle cycle between ticks.
  localparam int DIV_INT_MIN = 2;

endpackage

// File: rtl/baud_os_phase_counter.sv
// -----------------------------------------------------------------------------
// baud_os_phase_counter
// Counts oversample ticks within one UART bit. It wraps from N_OVERSAMPLE-1
// to 0 and raises o_wrap for the single cycle after the wrapping advance.
// A preload re-centres the phase at mid-bit, which is used on a start-bit
// restart.
// Ports:
//   i_clock    rising-edge clock
//   i_reset    synchronous active-high reset (phase 0, no wrap)
//   i_advance  one oversample tick occurred this cycle
//   i_preload  force the phase to N_OVERSAMPLE/2 (wins over i_advance)
//   o_phase    current phase, registered
//   o_wrap     registered wrap pulse, coincident with the phase returning to 0
// -----------------------------------------------------------------------------
module baud_os_phase_counter #(
  parameter int N_OVERSAMPLE = 16,
  parameter int NB_OS        = $clog2(N_OVERSAMPLE)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_advance,
  input  logic             i_preload,
  output logic [NB_OS-1:0] o_phase,
  output logic             o_wrap
);

  localparam logic [NB_OS-1:0] PHASE_LAST = NB_OS'(N_OVERSAMPLE - 1);
  localparam logic [NB_OS-1:0] PHASE_MID  = NB_OS'(N_OVERSAMPLE / 2);

  logic [NB_OS-1:0] r_phase;
  logic             r_wrap;

  // NOTE: registers are written only with non-blocking assignments, so every
  // flop in the design samples pre-edge values regardless of process order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (i_preload) begin
      r_phase <= PHASE_MID;
      r_wrap  <= 1'b0;
    end else if (i_advance) begin
      // Compare against the last phase rather than relying on natural
      // overflow, so a non-power-of-two N_OVERSAMPLE also works.
      if (r_phase == PHASE_LAST) begin
        r_phase <= '0;
        r_wrap  <= 1'b1;
      end else begin
        r_phase <= r_phase + NB_OS'(1);
        r_wrap  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_phase = r_phase;
  assign o_wrap  = r_wrap;

endmodule

// File: rtl/baud_tick_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_tick_gen_frac
// Fractional baud-tick generator. It emits a one-cycle oversample tick with an
// average period of div_int + div_frac/2^NB_FRAC cycles, and a bit tick every
// N_OVERSAMPLE oversample ticks. A new divisor is staged in a shadow register
// and takes effect at the next period boundary or restart. A restart realigns
// the phase to mid-bit when a start bit is detected.
// Ports:
//   i_clock       rising-edge clock
//   i_reset       synchronous active-high reset
//   i_enable      run (1) / freeze (0)
//   i_div_int     new integer divisor
//   i_div_frac    new fractional divisor
//   i_div_load    strobe: capture i_div_int/i_div_frac into the shadow register
//   i_restart     strobe: realign the phase (acts even while disabled)
//   o_tick        registered oversample tick
//   o_bit_tick    registered bit tick, always coincident with o_tick
//   o_os_phase    current oversample phase
//   o_div_active  active divisor {int, frac}
// -----------------------------------------------------------------------------
module baud_tick_gen_frac
  import uart_pkg::DIV_INT_MIN;
#(
  parameter int NB_DIV           = 16,
  parameter int NB_FRAC          = uart_pkg::NB_FRAC,
  parameter int N_OVERSAMPLE     = uart_pkg::OVERSAMPLE,
  parameter int DEFAULT_DIV_INT  = uart_pkg::DIV_INT,
  parameter int DEFAULT_DIV_FRAC = uart_pkg::DIV_FRAC,
  localparam int NB_OS           = $clog2(N_OVERSAMPLE)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [NB_DIV-1:0]         i_div_int,
  input  logic [NB_FRAC-1:0]        i_div_frac,
  input  logic                      i_div_load,
  input  logic                      i_restart,
  output logic                      o_tick,
  output logic                      o_bit_tick,
  output logic [NB_OS-1:0]          o_os_phase,
  output logic [NB_DIV+NB_FRAC-1:0] o_div_active
);

  localparam logic [NB_DIV-1:0]  DEF_INT  = NB_DIV'(DEFAULT_DIV_INT);
  localparam logic [NB_FRAC-1:0] DEF_FRAC = NB_FRAC'(DEFAULT_DIV_FRAC);

  // Integer divisors below the minimum are treated as the minimum.
  function automatic logic [NB_DIV-1:0] clamp_div(input logic [NB_DIV-1:0] d);
    return (d < NB_DIV'(DIV_INT_MIN)) ? NB_DIV'(DIV_INT_MIN) : d;
  endfunction

  logic [NB_DIV-1:0]  r_cnt;
  logic [NB_FRAC-1:0] r_acc;
  logic [NB_DIV-1:0]  r_div_int;
  logic [NB_FRAC-1:0] r_div_frac;
  logic [NB_DIV-1:0]  r_shd_int;
  logic [NB_FRAC-1:0] r_shd_frac;
  logic               r_pending;
  logic               r_tick;

  logic               w_boundary;
  logic               w_advance;
  logic [NB_DIV-1:0]  w_bnd_int;
  logic [NB_FRAC-1:0] w_bnd_frac;
  logic [NB_DIV-1:0]  w_rst_int;
  logic [NB_FRAC-1:0] w_rst_frac;
  logic [NB_FRAC:0]   w_acc_sum;
  logic [NB_DIV-1:0]  w_bnd_reload;
  logic [NB_DIV-1:0]  w_rst_reload;
  logic [NB_OS-1:0]   w_phase;
  logic               w_bit_tick;

  // NOTE: every signal in this block is assigned on every path, so no latch
  // is inferred.
  always_comb begin
    w_boundary = i_enable && (r_cnt == '0);
    w_advance  = w_boundary && !i_restart;

    // At a boundary, a pending shadow value becomes active before it is used.
    w_bnd_int  = r_pending ? r_shd_int  : r_div_int;
    w_bnd_frac = r_pending ? r_shd_frac : r_div_frac;

    // A restart also applies a load that arrives in the same cycle.
    w_rst_int  = i_div_load ? i_div_int  : w_bnd_int;
    w_rst_frac = i_div_load ? i_div_frac : w_bnd_frac;

    // The accumulator carry stretches this period by one cycle. That spreads
    // the fractional part evenly over 2^NB_FRAC periods.
    w_acc_sum    = {1'b0, r_acc} + {1'b0, w_bnd_frac};
    w_bnd_reload = clamp_div(w_bnd_int) - NB_DIV'(1) + NB_DIV'(w_acc_sum[NB_FRAC]);
    w_rst_reload = clamp_div(w_rst_int) - NB_DIV'(1);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt      <= clamp_div(DEF_INT) - NB_DIV'(1);
      r_acc      <= '0;
      r_div_int  <= DEF_INT;
      r_div_frac <= DEF_FRAC;
      r_shd_int  <= DEF_INT;
      r_shd_frac <= DEF_FRAC;
      r_pending  <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      // The shadow register captures a load in every mode, including while
      // frozen.
      if (i_div_load) begin
        r_shd_int  <= i_div_int;
        r_shd_frac <= i_div_frac;
      end

      if (i_restart) begin
        r_cnt      <= w_rst_reload;
        r_acc      <= '0;
        r_div_int  <= w_rst_int;
        r_div_frac <= w_rst_frac;
        r_pending  <= 1'b0;
        r_tick     <= 1'b0;
      end else if (w_boundary) begin
        r_cnt      <= w_bnd_reload;
        r_acc      <= w_acc_sum[NB_FRAC-1:0];
        r_div_int  <= w_bnd_int;
        r_div_frac <= w_bnd_frac;
        // A load that coincides with the boundary waits for the next one.
        r_pending  <= i_div_load;
        r_tick     <= 1'b1;
      end else begin
        if (i_enable) begin
          r_cnt <= r_cnt - NB_DIV'(1);
        end
        if (i_div_load) begin
          r_pending <= 1'b1;
        end
        r_tick <= 1'b0;
      end
    end
  end

  baud_os_phase_counter #(
    .N_OVERSAMPLE (N_OVERSAMPLE),
    .NB_OS        (NB_OS)
  ) u_phase (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_advance (w_advance),
    .i_preload (i_restart),
    .o_phase   (w_phase),
    .o_wrap    (w_bit_tick)
  );

  assign o_tick       = r_tick;
  assign o_bit_tick   = w_bit_tick;
  assign o_os_phase   = w_phase;
  assign o_div_active = {r_div_int, r_div_frac};

endmodule

// File: tb/tb_baud_tick_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baud_tick_gen_frac
// Directed and randomized stimulus for baud_tick_gen_frac with the default
// parameters (16-bit int, 4-bit frac, x16 oversampling, 162.75 default).
//
// The reference model predicts tick times in closed form. After an anchor
// (reset, restart, or a boundary that applies a new divisor) at enabled-cycle
// T0, with accumulator a0 before the anchor's own addition, tick j falls on
// enabled cycle T0 + j*int + floor((a0 + j*frac) / 16). For reset and restart
// anchors, a0 = -frac, because the first period carries no fraction.
// -----------------------------------------------------------------------------
module tb_baud_tick_gen_frac;

  localparam int DEF_INT  = 162;
  localparam int DEF_FRAC = 12;
  localparam int N_OS     = 16;
  localparam int FRAC_ONE = 16;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b1;
  logic [15:0] i_div_int = '0;
  logic [3:0]  i_div_frac = '0;
  logic        i_div_load = 1'b0;
  logic        i_restart = 1'b0;
  logic        o_tick;
  logic        o_bit_tick;
  logic [3:0]  o_os_phase;
  logic [19:0] o_div_active;

  baud_tick_gen_frac dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_div_int    (i_div_int),
    .i_div_frac   (i_div_frac),
    .i_div_load   (i_div_load),
    .i_restart    (i_restart),
    .o_tick       (o_tick),
    .o_bit_tick   (o_bit_tick),
    .o_os_phase   (o_os_phase),
    .o_div_active (o_div_active)
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int m_int, m_frac, m_shd_int, m_shd_frac, m_pend;
  int m_en, m_t0, m_a0, m_j, m_phase;
  int exp_tick, exp_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_tick_at();
    int jn;
    int ie;
    jn = m_j + 1;
    ie = (m_int < 2) ? 2 : m_int;
    return m_t0 + jn * ie + (m_a0 + jn * m_frac) / FRAC_ONE;
  endfunction

  task automatic anchor_restart();
    m_t0 = m_en;
    m_a0 = -m_frac;
    m_j  = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    int a;
    exp_tick = 0;
    exp_bit  = 0;
    if (i_reset) begin
      m_int = DEF_INT;  m_frac = DEF_FRAC;
      m_shd_int = DEF_INT; m_shd_frac = DEF_FRAC;
      m_pend = 0; m_en = 0; m_phase = 0;
      anchor_restart();
    end else if (i_restart) begin
      if (i_div_load) begin
        m_int = int'(i_div_int); m_frac = int'(i_div_frac);
        m_shd_int = m_int; m_shd_frac = m_frac;
      end else if (m_pend != 0) begin
        m_int = m_shd_int; m_frac = m_shd_frac;
      end
      m_pend  = 0;
      m_phase = N_OS / 2;
      anchor_restart();
    end else begin
      if (i_enable) begin
        m_en++;
        if (m_en == next_tick_at()) begin
          m_j++;
          exp_tick = 1;
          m_phase  = (m_phase + 1) % N_OS;
          exp_bit  = (m_phase == 0) ? 1 : 0;
          if (m_pend != 0) begin
            // Accumulator value before this boundary's addition.
            a = (m_a0 + m_j * m_frac) % FRAC_ONE;
            m_int = m_shd_int; m_frac = m_shd_frac; m_pend = 0;
            m_t0 = m_en; m_a0 = a; m_j = 0;
          end
        end
      end
      if (i_div_load) begin
        m_shd_int = int'(i_div_int); m_shd_frac = int'(i_div_frac); m_pend = 1;
      end
    end
  endtask

  // One clock: update the model at the edge, then compare all outputs 1 ns later.
  task automatic step();
    logic [19:0] exp_div;
    @(posedge i_clock);
    model_edge();
    #1;
    exp_div = {16'(m_int), 4'(m_frac)};
    check("tick",  32'(o_tick),       32'(exp_tick));
    check("bit",   32'(o_bit_tick),   32'(exp_bit));
    check("phase", 32'(o_os_phase),   32'(m_phase));
    check("div",   32'(o_div_active), 32'(exp_div));
  endtask

  // Step until o_tick is seen or the budget runs out. n returns the number of
  // steps taken.
  task automatic wait_tick(input string tag, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (o_tick !== 1'b1 && n < budget);
    check(tag, 32'(o_tick), 32'd1);
  endtask

  task automatic do_load(input int di, input int df);
    i_div_int  = 16'(di);
    i_div_frac = 4'(df);
    i_div_load = 1'b1;
    step();
    i_div_load = 1'b0;
  endtask

  int n, e, bits, first_bit, second_bit, ticks;
  int def_edges [6] = '{162, 324, 487, 650, 813, 975};

  initial begin
    // ---- Reset state ----
    repeat (3) step();
    check("rst_tick",  32'(o_tick),       32'd0);
    check("rst_bit",   32'(o_bit_tick),   32'd0);
    check("rst_phase", 32'(o_os_phase),   32'd0);
    check("rst_div",   32'(o_div_active), 32'h00A2C);
    i_reset = 1'b0;

    // ---- Defaults: tick edges, 200-interval span, bit ticks ----
    e = 0;
    for (int k = 0; k < 6; k++) begin
      wait_tick("def_seen", 400, n);
      e += n;
      check("def_edge", 32'(e), 32'(def_edges[k]));
    end
    bits = 0;
    for (int k = 6; k < 201; k++) begin
      wait_tick("def_seen", 400, n);
      e += n;
      bits += int'(o_bit_tick);
    end
    check("def_span200", 32'(e - 162), 32'd32550);
    check("def_bits",    32'(bits),    32'd12);
    check("def_phase",   32'(o_os_phase), 32'd9);

    // ---- Restart exactly on a boundary cycle ----
    for (int k = 0; k < 200 && next_tick_at() != m_en + 1; k++) step();
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    check("rs_notick", 32'(o_tick),     32'd0);
    check("rs_phase",  32'(o_os_phase), 32'd8);
    wait_tick("rs_seen", 400, n);
    check("rs_first", 32'(n), 32'd162);
    first_bit = 0; second_bit = 0;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) wait_tick("rs_seen", 400, n);
      if (o_bit_tick === 1'b1) begin
        if (first_bit == 0) first_bit = k;
        else if (second_bit == 0) second_bit = k;
      end
    end
    check("rs_bit1", 32'(first_bit),  32'd8);
    check("rs_bit2", 32'(second_bit), 32'd24);

    // ---- Divisor load mid-period ----
    repeat (50) step();
    do_load(10, 0);
    wait_tick("ld_seen", 400, n);
    check("ld_old_period", 32'((51 + n == 162) || (51 + n == 163)), 32'd1);
    check("ld_div", 32'(o_div_active), 32'h000A0);
    for (int k = 0; k < 3; k++) begin
      wait_tick("ld_seen", 40, n);
      check("ld_interval", 32'(n), 32'd10);
    end

    // ---- Restart together with a load of 20 ----
    i_div_int = 16'd20; i_div_frac = 4'd0; i_div_load = 1'b1; i_restart = 1'b1;
    step();
    i_div_load = 1'b0; i_restart = 1'b0;
    check("rsld_div", 32'(o_div_active), 32'h00140);
    wait_tick("rsld_seen", 100, n);
    check("rsld_first", 32'(n), 32'd20);

    // ---- Enable freeze with 40 cycles remaining, then clamp via load of 1 ----
    i_div_int = 16'd100; i_div_frac = 4'd0; i_div_load = 1'b1; i_restart = 1'b1;
    step();
    i_div_load = 1'b0; i_restart = 1'b0;
    repeat (60) step();
    i_enable = 1'b0;
    ticks = 0;
    for (int c = 0; c < 50; c++) begin
      i_div_int  = 16'd1;
      i_div_frac = 4'd0;
      i_div_load = (c == 20) ? 1'b1 : 1'b0;
      step();
      ticks += int'(o_tick);
    end
    i_div_load = 1'b0;
    check("dis_noticks", 32'(ticks), 32'd0);
    i_enable = 1'b1;
    wait_tick("en_seen", 200, n);
    check("en_resume", 32'(n), 32'd40);
    check("clamp_div", 32'(o_div_active), 32'h00010);
    for (int k = 0; k < 3; k++) begin
      wait_tick("clamp_seen", 10, n);
      check("clamp_interval", 32'(n), 32'd2);
    end

    // ---- Reset with a load pending ----
    do_load(7, 3);
    i_reset = 1'b1;
    step();
    check("rst2_tick",  32'(o_tick),       32'd0);
    check("rst2_bit",   32'(o_bit_tick),   32'd0);
    check("rst2_phase", 32'(o_os_phase),   32'd0);
    check("rst2_div",   32'(o_div_active), 32'h00A2C);
    i_reset = 1'b0;
    wait_tick("rst2_seen", 400, n);
    check("rst2_first",   32'(n), 32'd162);
    check("rst2_div_kept", 32'(o_div_active), 32'h00A2C);

    // ---- Randomized operation against the model ----
    for (int c = 0; c < 4000; c++) begin
      i_enable   = ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0;
      i_div_load = ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0;
      i_div_int  = 16'($urandom_range(0, 24));
      i_div_frac = 4'($urandom_range(0, 15));
      i_restart  = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      step();
    end
    i_div_load = 1'b0;
    i_restart  = 1'b0;
    i_enable   = 1'b1;
    repeat (60) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
